hack_boot_ctrl: RTL and testbench

HACK_BOOT_CTRL -- requirements
Module: hack_boot_ctrl

---
 rtl/hack_boot_pkg.sv | 18 +
 rtl/hack_boot_wdt.sv | 38 +++
 rtl/hack_boot_ctrl.sv | 159 +++++++++++++++
 tb/tb_hack_boot_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hack_boot_pkg.sv
// Shared types and defaults for the HACK boot loader (state encoding, data width, parameter defaults).
// Optional checksum word is enabled with HACK_BOOT_CHECKSUM_EN.
package hack_boot_pkg;

    localparam int DATA_W      = 16;
    localparam int DEF_ADDR_W  = 15;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CHK     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

endpackage

// File: rtl/hack_boot_wdt.sv
// Idle watchdog: counts enabled cycles since the last clear; expired is combinational from the count.
// Saturates at TIMEOUT so a stalled controller never sees the flag drop by wrap-around.
module hack_boot_wdt
    import hack_boot_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic xrst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q >= CNT_W'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hack_boot_ctrl.sv
// Boot controller: streams len words into instruction memory (1-cycle write latency), then releases the core.
// Define HACK_BOOT_CHECKSUM_EN to require a trailing checksum word before release.
module hack_boot_ctrl
    import hack_boot_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              start,
    input  logic [DATA_W-1:0] len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [DATA_W-1:0] rom_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] len_q;
    logic [DATA_W-1:0] cnt_q;
    logic              rom_we_q;
    logic [ADDR_W-1:0] rom_waddr_q;
    logic [DATA_W-1:0] rom_wdata_q;
`ifdef HACK_BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q;
`endif
    logic              start_ok;
    logic              beat;
    logic              load_beat;
    logic              last_beat;
    logic              expired;

    // start is only honoured where the core is not mid-load
    assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_ERR);
    assign beat      = s_valid && s_ready;
    assign load_beat = beat && (state_q == ST_LOAD);
    assign last_beat = load_beat && ((cnt_q + 16'd1) == len_q);

    assign rom_we    = rom_we_q;
    assign rom_waddr = rom_waddr_q;
    assign rom_wdata = rom_wdata_q;

    hack_boot_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk     (clk),
        .xrst    (xrst),
        .clear   (beat || start_ok),
        .enable  (state_q == ST_LOAD || state_q == ST_CHK),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) begin
                    state_d = (len == '0) ? ST_RELEASE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (last_beat) begin
`ifdef HACK_BOOT_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_RELEASE;
`endif
                end else if (!beat && expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_CHK: begin
`ifdef HACK_BOOT_CHECKSUM_EN
                if (beat) begin
                    state_d = (s_data == acc_q) ? ST_RELEASE : ST_ERR;
                end else if (expired) begin
                    state_d = ST_ERR;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RELEASE: state_d = ST_RUN;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        core_rst = 1'b1;
        case (state_q)
            ST_LOAD: begin
                s_ready = (cnt_q < len_q);
                busy    = 1'b1;
            end
            ST_CHK: begin
`ifdef HACK_BOOT_CHECKSUM_EN
                s_ready = 1'b1;
`endif
                busy    = 1'b1;
            end
            ST_RELEASE: done = 1'b1;
            ST_RUN: begin
                done     = 1'b1;
                core_rst = 1'b0;
            end
            ST_ERR:  err = 1'b1;
            default: ;
        endcase
    end

    // Address is the low bits of the word count, so oversize images simply wrap
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            len_q       <= '0;
            cnt_q       <= '0;
            rom_we_q    <= 1'b0;
            rom_waddr_q <= '0;
            rom_wdata_q <= '0;
`ifdef HACK_BOOT_CHECKSUM_EN
            acc_q       <= '0;
`endif
        end else begin
            rom_we_q <= load_beat;
            if (load_beat) begin
                rom_waddr_q <= cnt_q[ADDR_W-1:0];
                rom_wdata_q <= s_data;
                cnt_q       <= cnt_q + 16'd1;
`ifdef HACK_BOOT_CHECKSUM_EN
                acc_q       <= acc_q + s_data;
`endif
            end
            if (start_ok) begin
                len_q <= len;
                cnt_q <= '0;
`ifdef HACK_BOOT_CHECKSUM_EN
                acc_q <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Directed bench for hack_boot_ctrl: stimulus pushes expected rom writes, a negedge monitor pops and compares.
module tb_hack_boot_ctrl;
    import hack_boot_pkg::*;

    localparam int ADDR_W  = 15;
    localparam int TIMEOUT = 1024;

    logic              clk = 1'b0;
    logic              xrst;
    logic              start;
    logic [15:0]       len;
    logic              s_valid;
    logic [15:0]       s_data;
    logic              s_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [15:0]       rom_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    wr_t exp_q[$];

    hack_boot_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .xrst      (xrst),
        .start     (start),
        .len       (len),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .rom_we    (rom_we),
        .rom_waddr (rom_waddr),
        .rom_wdata (rom_wdata),
        .core_rst  (core_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic st(input string tag, input bit c, input bit b, input bit d, input bit e);
        chk({tag, "_core_rst"}, 32'(core_rst), 32'(c));
        chk({tag, "_busy"},     32'(busy),     32'(b));
        chk({tag, "_done"},     32'(done),     32'(d));
        chk({tag, "_err"},      32'(err),      32'(e));
    endtask

    // Monitor: every rom write must match the oldest outstanding expectation
    always @(negedge clk) begin
        wr_t e;
        if (rom_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", rom_waddr, rom_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(rom_waddr), 32'(e.addr));
                chk("write_data", 32'(rom_wdata), 32'(e.data));
            end
        end
    end

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        len   = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic [ADDR_W-1:0] a, input bit wr);
        wr_t w;
        chk("s_ready_at_beat", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = d;
        if (wr) begin
            w.addr = a;
            w.data = d;
            exp_q.push_back(w);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic finish_load(input logic [15:0] sum);
`ifdef HACK_BOOT_CHECKSUM_EN
        st("chk_state", 1, 1, 0, 0);
        send(sum, '0, 1'b0);
`else
        chk("load_sum_unused", 32'(sum), 32'(sum));
        checks--;
`endif
    endtask

    initial begin
        int cyc;
        xrst    = 1'b1;
        start   = 1'b0;
        len     = '0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (2) @(negedge clk);
        st("reset", 1, 0, 0, 0);
        chk("reset_s_ready",   32'(s_ready),   32'd0);
        chk("reset_rom_we",    32'(rom_we),    32'd0);
        chk("reset_rom_waddr", 32'(rom_waddr), 32'd0);
        chk("reset_rom_wdata", 32'(rom_wdata), 32'd0);
        xrst = 1'b0;
        @(negedge clk);
        st("idle", 1, 0, 0, 0);

        // Three back-to-back words
        do_start(16'd3);
        st("A_load", 1, 1, 0, 0);
        send(16'h0010, 15'd0, 1'b1);
        send(16'hE308, 15'd1, 1'b1);
        send(16'h0002, 15'd2, 1'b1);
        finish_load(16'hE31A);
        st("A_release", 1, 0, 1, 0);
        @(negedge clk);
        st("A_run", 0, 0, 1, 0);
        chk("A_writes_drained", 32'(exp_q.size()), 32'd0);

        // Reload from RUN
        do_start(16'd1);
        st("B_reload", 1, 1, 0, 0);
        send(16'hABCD, 15'd0, 1'b1);
        finish_load(16'hABCD);
        st("B_release", 1, 0, 1, 0);
        @(negedge clk);
        st("B_run", 0, 0, 1, 0);

        // Zero-length image: straight to release, no writes
        do_start(16'd0);
        st("C_release", 1, 0, 1, 0);
        @(negedge clk);
        st("C_run", 0, 0, 1, 0);

        // Stall after one of two words until the watchdog fires
        do_start(16'd2);
        send(16'h5555, 15'd0, 1'b1);
        cyc = 0;
        while (err !== 1'b1 && cyc < 1500) begin
            @(negedge clk);
            cyc++;
        end
        chk("D_timeout_cycles", 32'(cyc), 32'd1025);
        st("D_err", 1, 0, 0, 1);
        chk("D_err_s_ready", 32'(s_ready), 32'd0);
        chk("D_err_rom_we",  32'(rom_we),  32'd0);
        do_start(16'd1);
        st("D_reload", 1, 1, 0, 0);
        send(16'h0077, 15'd0, 1'b1);
        finish_load(16'h0077);
        st("D_release", 1, 0, 1, 0);
        @(negedge clk);
        st("D_run", 0, 0, 1, 0);

`ifdef HACK_BOOT_CHECKSUM_EN
        do_start(16'd2);
        send(16'h1234, 15'd0, 1'b1);
        send(16'h0001, 15'd1, 1'b1);
        finish_load(16'h1235);
        st("E_good_release", 1, 0, 1, 0);
        @(negedge clk);
        st("E_good_run", 0, 0, 1, 0);
        do_start(16'd2);
        send(16'h1234, 15'd0, 1'b1);
        send(16'h0001, 15'd1, 1'b1);
        finish_load(16'h1236);
        st("E_bad_err", 1, 0, 0, 1);
        chk("E_writes_drained", 32'(exp_q.size()), 32'd0);
        do_start(16'd0);
        @(negedge clk);
        st("E_recover_run", 0, 0, 1, 0);
`endif

        // Reset pulsed after two of four beats, with a third beat pending
        do_start(16'd4);
        send(16'h1111, 15'd0, 1'b1);
        send(16'h2222, 15'd1, 1'b1);
        s_valid = 1'b1;
        s_data  = 16'h3333;
        #2 xrst = 1'b1;
        #1;
        st("F_rst", 1, 0, 0, 0);
        chk("F_rst_s_ready",   32'(s_ready),   32'd0);
        chk("F_rst_rom_we",    32'(rom_we),    32'd0);
        chk("F_rst_rom_waddr", 32'(rom_waddr), 32'd0);
        chk("F_rst_rom_wdata", 32'(rom_wdata), 32'd0);
        @(negedge clk);
        xrst = 1'b0;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        st("F_idle", 1, 0, 0, 0);

        chk("final_writes_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
